// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunk-serial adder.
// Holds the FSM encoding and a helper that sizes the chunk counter.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A one-chunk configuration still needs a 1-bit counter to exist.
  function automatic int counterWidth(input int nChunk);
    return (nChunk > 1) ? $clog2(nChunk) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Start/ready/done handshake and result bus of the chunk-serial adder.
// The requester drives master; the adder sits on slave.
interface seq_chunk_adder_if #(parameter int WIDTH = 16);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  ready, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output ready, done, sum, cout, ovf
  );

endinterface

// File: rtl/seq_chunk_adder_chunk_adder.sv
// CHUNK-bit ripple chain of full-adder cells; purely combinational.
// cmsb_o is the carry entering the top bit, needed for signed overflow.
module seq_chunk_adder_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  // The carry is rippled through a loop-local variable so the chain
  // does not feed back through a single vector signal.
  always_comb begin
    logic carry;
    carry  = cin_i;
    sum_o  = '0;
    cmsb_o = cin_i;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) begin
        cmsb_o = carry;
      end
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle two's-complement adder: adds WIDTH-bit operands CHUNK bits per
// clock, LSB chunk first, and publishes Sum/Cout/Ovf only on completion.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst,
  seq_chunk_adder_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = counterWidth(NCHUNK);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : gBadParams
      $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] part_q;
  logic [WIDTH-1:0] part_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             ready_q;
  logic             done_q;

  logic [CHUNK-1:0] chunkA;
  logic [CHUNK-1:0] chunkB;
  logic [CHUNK-1:0] chunkSum;
  logic             chunkCout;
  logic             chunkCmsb;

  // Select chunk k of the latched operands with constant slices only.
  always_comb begin
    chunkA = '0;
    chunkB = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        chunkA = a_q[i*CHUNK +: CHUNK];
        chunkB = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  seq_chunk_adder_chunk_adder #(.CHUNK(CHUNK)) uChunk (
    .a_i    (chunkA),
    .b_i    (chunkB),
    .cin_i  (carry_q),
    .sum_o  (chunkSum),
    .cout_o (chunkCout),
    .cmsb_o (chunkCmsb)
  );

  always_comb begin
    part_d = part_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        part_d[i*CHUNK +: CHUNK] = chunkSum;
      end
    end
  end

  // Single FSM with registered handshake and result outputs; the result
  // registers load only on the final RUN cycle, so partials stay hidden.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            k_q     <= '0;
            part_q  <= '0;
            ready_q <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          part_q  <= part_d;
          carry_q <= chunkCout;
          k_q     <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            sum_q   <= part_d;
            cout_q  <= chunkCout;
            ovf_q   <= chunkCmsb ^ chunkCout;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench: directed vector table on a 16/4 adder, handshake corner
// sequences, an 8/8 degenerate case and a random sweep at CHUNK=1, 4 and 16.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(16)) bus4 ();
  seq_chunk_adder_if #(.WIDTH(16)) bus1 ();
  seq_chunk_adder_if #(.WIDTH(16)) bus16 ();
  seq_chunk_adder_if #(.WIDTH(8))  bus8 ();

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  seq_chunk_adder #(.WIDTH(8),  .CHUNK(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vecT;

  int checks = 0;
  int errors = 0;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One operation on the 16/4 adder; returns results and edges from accept to Done.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                               output logic [15:0] s, output logic co, output logic ov,
                               output int lat);
    logic [15:0] prevSum;
    bit leaked;
    prevSum = bus4.sum;
    leaked  = 1'b0;
    lat     = -1;
    checkOutput("ready before start", 32'(bus4.ready), 32'd1);
    bus4.a     = a;
    bus4.b     = b;
    bus4.cin   = cin;
    bus4.start = 1'b1;
    stepCycle();
    bus4.start = 1'b0;
    bus4.a     = ~a;
    bus4.b     = ~b;
    bus4.cin   = ~cin;
    for (int n = 1; n <= 20; n++) begin
      if (bus4.sum !== prevSum) leaked = 1'b1;
      stepCycle();
      if (bus4.done) begin
        lat = n;
        break;
      end
    end
    s  = bus4.sum;
    co = bus4.cout;
    ov = bus4.ovf;
    checkOutput("partial sum hidden", 32'(leaked), 32'd0);
    stepCycle();
    checkOutput("done single pulse", 32'(bus4.done), 32'd0);
    checkOutput("ready after done", 32'(bus4.ready), 32'd1);
  endtask

  // Same operands into the 16-bit adders at CHUNK=1, 4 and 16, checked against A+B+Cin.
  task automatic runRandom(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [17:0] res1, res4, res16, expRes;
    logic [16:0] full;
    logic        expOvf;
    res1  = 'x;
    res4  = 'x;
    res16 = 'x;
    bus1.a = a;  bus1.b = b;  bus1.cin = cin;  bus1.start = 1'b1;
    bus4.a = a;  bus4.b = b;  bus4.cin = cin;  bus4.start = 1'b1;
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.start = 1'b1;
    stepCycle();
    bus1.start = 1'b0;
    bus4.start = 1'b0;
    bus16.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      stepCycle();
      if (bus1.done)  res1  = {bus1.cout, bus1.ovf, bus1.sum};
      if (bus4.done)  res4  = {bus4.cout, bus4.ovf, bus4.sum};
      if (bus16.done) res16 = {bus16.cout, bus16.ovf, bus16.sum};
      if (bus1.ready && bus4.ready && bus16.ready) break;
    end
    full   = {1'b0, a} + {1'b0, b} + 17'(cin);
    expOvf = (a[15] == b[15]) && (full[15] != a[15]);
    expRes = {full[16], expOvf, full[15:0]};
    checkOutput("random chunk1",  32'(res1),  32'(expRes));
    checkOutput("random chunk4",  32'(res4),  32'(expRes));
    checkOutput("random chunk16", 32'(res16), 32'(expRes));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecT         vecs[8];
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    int          doneCount;
    logic [15:0] heldSum;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[5] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    bus4.start = 0;  bus4.a = '0;  bus4.b = '0;  bus4.cin = 0;
    bus1.start = 0;  bus1.a = '0;  bus1.b = '0;  bus1.cin = 0;
    bus16.start = 0; bus16.a = '0; bus16.b = '0; bus16.cin = 0;
    bus8.start = 0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 0;

    rst = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("reset ready", 32'(bus4.ready), 32'd1);
    checkOutput("reset done",  32'(bus4.done),  32'd0);
    checkOutput("reset sum",   32'(bus4.sum),   32'd0);
    checkOutput("reset cout",  32'(bus4.cout),  32'd0);
    checkOutput("reset ovf",   32'(bus4.ovf),   32'd0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] directed vectors, WIDTH=16 CHUNK=4");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, lat);
      checkOutput($sformatf("vec%0d sum", i),     32'(s),  32'(vecs[i].sum));
      checkOutput($sformatf("vec%0d cout", i),    32'(co), 32'(vecs[i].cout));
      checkOutput($sformatf("vec%0d ovf", i),     32'(ov), 32'(vecs[i].ovf));
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
    end
    stepCycle();
    stepCycle();
    checkOutput("sum held while idle", 32'(bus4.sum), 32'h7FFF);

    $display("[TB] start held high with changing operands");
    doneCount = 0;
    heldSum   = 'x;
    bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.cin = 1'b0; bus4.start = 1'b1;
    stepCycle();
    for (int n = 0; n < 20; n++) begin
      bus4.a   = bus4.a + 16'h0101;
      bus4.b   = bus4.b + 16'h0202;
      bus4.cin = ~bus4.cin;
      stepCycle();
      if (bus4.done) begin
        doneCount++;
        heldSum    = bus4.sum;
        bus4.start = 1'b0;
        break;
      end
    end
    bus4.start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      stepCycle();
      if (bus4.done) doneCount++;
    end
    checkOutput("held start done count", 32'(doneCount), 32'd1);
    checkOutput("held start sum", 32'(heldSum), 32'h3333);
    checkOutput("held start ready", 32'(bus4.ready), 32'd1);

    $display("[TB] reset during second RUN cycle");
    bus4.a = 16'h00FF; bus4.b = 16'h0001; bus4.cin = 1'b0; bus4.start = 1'b1;
    stepCycle();
    bus4.start = 1'b0;
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("midop reset ready", 32'(bus4.ready), 32'd1);
    checkOutput("midop reset sum",   32'(bus4.sum),   32'd0);
    checkOutput("midop reset done",  32'(bus4.done),  32'd0);
    doneCount = 0;
    for (int n = 0; n < 6; n++) begin
      stepCycle();
      if (bus4.done) doneCount++;
    end
    checkOutput("no done after reset", 32'(doneCount), 32'd0);
    applyStimulus(16'h00FF, 16'h0001, 1'b0, s, co, ov, lat);
    checkOutput("post reset sum", 32'(s), 32'h0100);
    checkOutput("post reset latency", 32'(lat), 32'd4);

    $display("[TB] degenerate WIDTH=CHUNK=8");
    lat = -1;
    checkOutput("w8 ready", 32'(bus8.ready), 32'd1);
    bus8.a = 8'hC8; bus8.b = 8'h64; bus8.cin = 1'b0; bus8.start = 1'b1;
    stepCycle();
    bus8.start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      stepCycle();
      if (bus8.done) begin
        lat = n;
        break;
      end
    end
    checkOutput("w8 latency", 32'(lat), 32'd1);
    checkOutput("w8 sum",  32'(bus8.sum),  32'h2C);
    checkOutput("w8 cout", 32'(bus8.cout), 32'd1);
    checkOutput("w8 ovf",  32'(bus8.ovf),  32'd0);
    stepCycle();
    checkOutput("w8 ready back", 32'(bus8.ready), 32'd1);

    $display("[TB] random sweep at CHUNK=1, 4, 16");
    for (int i = 0; i < 1000; i++) begin
      runRandom(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Multi-cycle, parametrised two's-complement adder that processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first. It keeps the carry in a register between chunks. It generalises the single-bit full adder to wide operands with a start/ready/done handshake, carry-out and signed-overflow flags. It serves datapaths that trade latency for a narrow adder slice.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
Start  input  1  request to begin an addition; accepted only when Ready=1.
A  input  WIDTH  operand A; sampled on the accepting edge.
B  input  WIDTH  operand B; sampled on the accepting edge.
Cin  input  1  carry-in to bit 0; sampled on the accepting edge.
Ready  output  1  high only in IDLE.
Done  output  1  one-cycle pulse when Sum/Cout/Ovf are updated.
Sum  output  WIDTH  result; holds the last completed value.
Cout  output  1  carry out of bit WIDTH-1.
Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: state=IDLE, Ready=1, Done=0, Sum=0, Cout=0, Ovf=0, chunk counter=0, carry reg=0, operand regs=0.
- FSM states:
  - IDLE: Ready=1. If Start=1, latch A, B, Cin (Cin into the carry reg), clear the counter and the partial-sum register, then go to RUN.
  - RUN: Ready=0. Each cycle, add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of the latched A and B plus the carry reg. Write the CHUNK-bit result into the partial-sum register at chunk k, update the carry reg, and increment k. On the cycle with k=NCHUNK-1, also capture the carry into the MSB for Ovf, then go to DONE.
  - DONE: Ready=0, Done=1 for exactly this cycle. Sum, Cout and Ovf take the final values on entry to DONE. Return to IDLE next cycle.
- Latency: Start accepted at edge t gives Done=1 in the cycle after edge t+NCHUNK. Ready returns at edge t+NCHUNK+1. Throughput is one result per NCHUNK+2 cycles.
- Visibility: Sum/Cout/Ovf change only on the edge entering DONE or on reset. Partial results are never visible.
- Start while Ready=0 is ignored; there is no queueing. A, B and Cin changes after acceptance have no effect.
- Reset mid-operation (RUN or DONE): return to IDLE next edge with all reset values. The operation is discarded and no Done pulse occurs.
- Arithmetic is modulo 2^WIDTH. Cout and Ovf are both computed and are independent of each other.
- CHUNK=WIDTH is a legal degenerate case (NCHUNK=1, single RUN cycle).

Decomposition:
- Shared include file holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) as localparams and the WIDTH%CHUNK==0 elaboration check.
- One combinational sub-module, chunk_adder:
  - Parametrised CHUNK-bit ripple chain of the existing full_adder cells.
  - Ports: A, B, Cin, Sum, Cout, Cmsb (carry into its top bit).
  - Instantiated once; the FSM muxes chunk k into it.

Test Plan:
1. WIDTH=16, CHUNK=4; A=16'hFFFF, B=16'h0001, Cin=0 -> Sum=16'h0000, Cout=1, Ovf=0. Done pulses in the cycle after edge t+4; Ready=1 again after edge t+5.
2. A=16'h7FFF, B=16'h0001, Cin=0 -> Sum=16'h8000, Cout=0, Ovf=1. A=16'h8000, B=16'h8000 -> Sum=16'h0000, Cout=1, Ovf=1.
3. A=0, B=0, Cin=1 -> Sum=16'h0001. Then A=16'h0F0F, B=16'h00F1, Cin=0 -> Sum=16'h1000 (carry crosses chunk boundaries).
4. Start held high through RUN/DONE with changing A/B -> only the first operation completes, one Done per accepted Start, and the result matches the first operands.
5. Assert rst on the 2nd RUN cycle -> next cycle Ready=1, Sum=0, no Done pulse. A following Start completes normally.
6. WIDTH=CHUNK=8; A=8'hC8, B=8'h64 -> Sum=8'h2C, Cout=1, Ovf=0, Done in the cycle after edge t+1. Random regression of 1000 operands against A+B+Cin at CHUNK=1, 4 and 16.
